maq_control_multi: RTL and testbench
====================================

# maq_control_multi

Parametrised general control machine for the RTC clock/alarm/chronometer system; successor to the fixed three-button general control FSM. It arbitrates NUM_REQ programming requests by fixed priority, sequences RTC bus transactions (init, periodic read, write-back) through a start/done handshake with timeout, and compares each completed time read against NUM_ALARM alarm slots. It sits between the push-button/switch inputs and the RTC bus driver, and provides the status and sync strobes consumed by the display path.

## Interface
- NUM_REQ, 3: number of programming request lines; index 0 has highest priority.
- NUM_ALARM, 2: number of alarm compare slots.
- READ_PERIOD, 100: clock cycles between periodic RTC reads while idle; must be ≥ 2.
- TIMEOUT, 64: cycles allowed for bus_done after bus_start.
- CRONO_IDX, 2: request index that enables the chronometer; must be < NUM_REQ.
- reloj  in  1  system clock; all logic on the rising edge.
- resetM  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  level programming requests (P_FECHA/P_HORA/P_CRONO generalised).
- r_rtc  in  1  re-initialise RTC request; level, sampled in IDLE.
- alarm_en  in  NUM_ALARM  per-slot enable; low clears that slot's hit.
- alarm_time  in  24*NUM_ALARM  slot i at [24i+23:24i], BCD hh:mm:ss.
- hora_actual  in  24  time from bus driver; valid in the cycle bus_done is high during READ.
- bus_done  in  1  one-cycle completion strobe from bus driver.
- bus_start  out  1  one-cycle transaction start strobe.
- Control  out  2  transaction type: 00 none, 01 init, 10 read, 11 write.
- act_crono  out  1  high while in PROG with grant == CRONO_IDX.
- status  out  3  state code: 0 IDLE, 1 INIT, 2 READ, 3 PROG, 4 WRITE.
- grant  out  clog2(NUM_REQ), min 1  index of the request currently being served.
- alarm_hit  out  NUM_ALARM  sticky alarm flags.
- sync  out  1  one-cycle pulse after each successful read.
- err  out  1  sticky timeout flag.

## Operation
- All outputs registered.
- Reset (resetM high at an edge) sets: state INIT with the entry flag set, period counter = READ_PERIOD-1, and every output 0.
- INIT: bus_start = 1 on the first cycle; Control = 01 for the whole state. bus_done moves the state to IDLE.
- IDLE: Control = 00. Period counter decrements each cycle. Priority, evaluated each cycle:
  - r_rtc → INIT.
  - Counter == 0 → READ.
  - Any req bit set → PROG; grant latched to the lowest set index.
- READ: Control = 10; bus_start on the first cycle.
  - On bus_done, hora_actual is latched and each slot i with alarm_en[i] and alarm_time slot == hora_actual sets alarm_hit[i]. sync pulses the same cycle. Next state IDLE.
- PROG: Control = 00. No periodic reads. req changes on other indices are ignored. When req[grant] falls → WRITE.
- WRITE: Control = 11; bus_start on the first cycle. bus_done → IDLE.
- Timeout: in INIT, READ or WRITE, TIMEOUT cycles without bus_done set err, and the state goes to IDLE with no alarm update and no sync. err clears on the next successful bus_done.
- Every entry to IDLE reloads the period counter to READ_PERIOD-1.
- alarm_hit[i] clears whenever alarm_en[i] is low. A new match wins over a clear only while alarm_en[i] is high.

## Timing
- State change to bus_start: both are visible at the same edge; bus_start lasts exactly 1 cycle.
- bus_done is honoured from the cycle after bus_start. A bus_done coincident with bus_start, or arriving outside INIT/READ/WRITE, is ignored.
- Timeout is declared at cycle TIMEOUT after bus_start (bus_start cycle = 0). A bus_done in that same cycle counts as success.
- First periodic read in idle: bus_start occurs READ_PERIOD cycles after entering IDLE.
- alarm_hit and sync update at the edge after the bus_done cycle.
- Reset mid-transaction: state returns to INIT. The bus driver is expected to abort on its own reset.
- Simultaneous r_rtc, read tick and req in IDLE: INIT is taken. The tick and the req stay pending and are served by priority after return.

## Structure
- Package maq_control_pkg holds: state encoding (which is also the status code), the Control codes, and a BCD time typedef (hh, mm, ss bytes).
- Sub-module alarm_cmp: one instance per slot via generate. It is a 24-bit compare plus a sticky flag with enable-clear.

## Test plan
- Reset then bus_done 3 cycles after bus_start → Control 01 during INIT, then status 0; first READ bus_start 100 cycles later.
- alarm_time slot0 = 24'h110001, alarm_en = 01, read returns 24'h110001 → alarm_hit = 01 and sync pulse; drop alarm_en[0] → alarm_hit = 00.
- req = 3'b110 → grant 1, status 3, act_crono 0. Raise req[0] → no change. Drop req[1] → WRITE with Control 11.
- req[2] only → act_crono 1 throughout PROG; periodic reads suppressed for 500 cycles.
- No bus_done in READ → err 1 at cycle 64, status 0, no sync. Next read completes → err 0.
- r_rtc, read tick and req[0] in the same cycle → INIT first, then READ, then PROG.

Source files
------------

// File: rtl/maq_control_pkg.sv
// maq_control_pkg: shared state codes, bus command codes and BCD time type for the RTC control machine
package maq_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_READ  = 3'd2,
        S_PROG  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_INIT  = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;
    localparam logic [1:0] C_WRITE = 2'b11;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

endpackage

// File: rtl/alarm_cmp.sv
// alarm_cmp: one alarm slot, BCD time compare on a completed read plus a sticky hit flag cleared by disable
module alarm_cmp
    import maq_control_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_chk,
    input  logic [23:0] i_alarm,
    input  logic [23:0] i_hora,
    output logic        o_hit
);

    bcd_time_t w_alarm;
    bcd_time_t w_hora;
    logic      w_match;

    assign w_alarm = i_alarm;
    assign w_hora  = i_hora;
    assign w_match = i_chk && (w_alarm == w_hora);

    // a disabled slot is held clear; an enabled slot latches any match until disabled
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en)
            o_hit <= 1'b0;
        else
            o_hit <= o_hit || w_match;
    end

endmodule

// File: rtl/maq_control_multi.sv
// maq_control_multi: prioritised RTC bus sequencer with periodic reads, request programming and alarm compare
module maq_control_multi
    import maq_control_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int NUM_ALARM   = 2,
    parameter int READ_PERIOD = 100,
    parameter int TIMEOUT     = 64,
    parameter int CRONO_IDX   = 2,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic                    reloj,
    input  logic                    resetM,
    input  logic [NUM_REQ-1:0]      req,
    input  logic                    r_rtc,
    input  logic [NUM_ALARM-1:0]    alarm_en,
    input  logic [24*NUM_ALARM-1:0] alarm_time,
    input  logic [23:0]             hora_actual,
    input  logic                    bus_done,
    output logic                    bus_start,
    output logic [1:0]              Control,
    output logic                    act_crono,
    output logic [2:0]              status,
    output logic [GW-1:0]           grant,
    output logic [NUM_ALARM-1:0]    alarm_hit,
    output logic                    sync,
    output logic                    err
);

    localparam int PW = $clog2(READ_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] W_RELOAD = PW'(READ_PERIOD - 1);

    state_t        r_state;
    logic          r_entry;
    logic          r_tick;
    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_tcnt;
    logic [GW-1:0] w_low;
    logic          w_live;
    logic          w_done;
    logic          w_tout;
    logic          w_tick;
    logic          w_chk;

    // a bus_done is only honoured in a transaction state and never in its bus_start cycle
    assign w_live = !r_entry && (r_state == S_INIT || r_state == S_READ || r_state == S_WRITE);
    assign w_done = w_live && bus_done && !bus_start;
    assign w_tout = w_live && !w_done && (r_tcnt == TW'(TIMEOUT));
    assign w_tick = r_tick || (r_pcnt == '0);
    assign w_chk  = w_done && (r_state == S_READ);

    // fixed priority: lowest active request index wins
    always_comb begin
        w_low = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            w_low = req[i] ? GW'(i) : w_low;
    end

    // sequencer: state, bus handshake, timeout, read period and registered outputs
    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_state   <= S_INIT;
            r_entry   <= 1'b1;
            r_tick    <= 1'b0;
            r_pcnt    <= W_RELOAD;
            r_tcnt    <= '0;
            bus_start <= 1'b0;
            Control   <= C_NONE;
            act_crono <= 1'b0;
            status    <= '0;
            grant     <= '0;
            sync      <= 1'b0;
            err       <= 1'b0;
        end else begin
            bus_start <= 1'b0;
            sync      <= 1'b0;
            r_tcnt    <= r_tcnt + 1'b1;
            if (r_entry) begin
                r_entry   <= 1'b0;
                bus_start <= 1'b1;
                Control   <= C_INIT;
                status    <= S_INIT;
                r_tcnt    <= '0;
            end else if (w_done || w_tout) begin
                r_state <= S_IDLE;
                status  <= S_IDLE;
                Control <= C_NONE;
                r_pcnt  <= W_RELOAD;
                err     <= w_tout;
                sync    <= w_chk;
            end else if (r_state == S_IDLE) begin
                r_pcnt <= (r_pcnt != '0) ? r_pcnt - 1'b1 : r_pcnt;
                if (r_rtc) begin
                    r_tick    <= w_tick;
                    r_state   <= S_INIT;
                    status    <= S_INIT;
                    Control   <= C_INIT;
                    bus_start <= 1'b1;
                    r_tcnt    <= '0;
                end else if (w_tick) begin
                    r_tick    <= 1'b0;
                    r_state   <= S_READ;
                    status    <= S_READ;
                    Control   <= C_READ;
                    bus_start <= 1'b1;
                    r_tcnt    <= '0;
                end else if (|req) begin
                    r_state   <= S_PROG;
                    status    <= S_PROG;
                    grant     <= w_low;
                    act_crono <= (w_low == GW'(CRONO_IDX));
                end
            end else if (r_state == S_PROG && !req[grant]) begin
                r_state   <= S_WRITE;
                status    <= S_WRITE;
                Control   <= C_WRITE;
                act_crono <= 1'b0;
                bus_start <= 1'b1;
                r_tcnt    <= '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_ALARM; g++) begin : g_alarm
        alarm_cmp u_cmp (
            .i_clk   (reloj),
            .i_rst   (resetM),
            .i_en    (alarm_en[g]),
            .i_chk   (w_chk),
            .i_alarm (alarm_time[24*g +: 24]),
            .i_hora  (hora_actual),
            .o_hit   (alarm_hit[g])
        );
    end

endmodule

// File: tb/tb_maq_control_multi.sv
// tb_maq_control_multi: scoreboard bench with a responsive bus-driver model and directed scenarios
module tb_maq_control_multi;

    logic        clk = 1'b0;
    logic        resetM = 1'b1;
    logic [2:0]  req = '0;
    logic        r_rtc = 1'b0;
    logic [1:0]  alarm_en = '0;
    logic [47:0] alarm_time = '0;
    logic [23:0] hora_actual = '0;
    logic        bus_done = 1'b0;
    logic        bus_start;
    logic [1:0]  Control;
    logic        act_crono;
    logic [2:0]  status;
    logic [1:0]  grant;
    logic [1:0]  alarm_hit;
    logic        sync;
    logic        err;

    logic [23:0] hora = '0;
    int          bus_delay = 3;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    typedef struct {
        logic       bs;
        logic [1:0] ctl;
        logic [2:0] st;
        logic [1:0] hit;
        logic       e;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    maq_control_multi dut (
        .reloj       (clk),
        .resetM      (resetM),
        .req         (req),
        .r_rtc       (r_rtc),
        .alarm_en    (alarm_en),
        .alarm_time  (alarm_time),
        .hora_actual (hora_actual),
        .bus_done    (bus_done),
        .bus_start   (bus_start),
        .Control     (Control),
        .act_crono   (act_crono),
        .status      (status),
        .grant       (grant),
        .alarm_hit   (alarm_hit),
        .sync        (sync),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus driver: answers each bus_start with a one-cycle bus_done bus_delay cycles later (never if <= 0)
    initial begin
        forever begin
            @(negedge clk);
            if (!resetM && bus_start && bus_delay > 0) begin
                repeat (bus_delay) @(posedge clk);
                #1 bus_done = 1'b1;
                hora_actual = hora;
                @(posedge clk);
                #1 bus_done = 1'b0;
            end
        end
    end

    // monitor: every bus_start or sync pulse consumes one expected event
    always @(negedge clk) begin
        if (!resetM && (bus_start || sync)) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL event_unexpected @%0d: bs=%0b sync=%0b ctl=%0b st=%0d", cyc, bus_start, sync, Control, status);
            end else begin
                m_e = q.pop_front();
                if ({bus_start, sync, Control, status, alarm_hit, err} !==
                    {m_e.bs, !m_e.bs, m_e.ctl, m_e.st, m_e.hit, m_e.e}) begin
                    fails++;
                    $display("FAIL event @%0d: got bs=%0b sync=%0b ctl=%0b st=%0d hit=%0b err=%0b, expected bs=%0b sync=%0b ctl=%0b st=%0d hit=%0b err=%0b",
                             cyc, bus_start, sync, Control, status, alarm_hit, err,
                             m_e.bs, !m_e.bs, m_e.ctl, m_e.st, m_e.hit, m_e.e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic bs, input logic [1:0] ctl, input logic [2:0] st, input logic [1:0] hit, input logic e);
        exp_t x;
        x.bs = bs; x.ctl = ctl; x.st = st; x.hit = hit; x.e = e;
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_bs(output int c);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus_start && n < 300);
        check("wait_bus_start", bus_start, 1);
        c = cyc;
    endtask

    task automatic wait_st(input logic [2:0] v, output int c);
        int n = 0;
        do begin @(negedge clk); n++; end while (status !== v && n < 300);
        check("wait_status", status, v);
        c = cyc;
    endtask

    initial begin
        int e, c, t;
        int bad;
        alarm_time = {24'h235959, 24'h110001};
        // reset state
        repeat (3) @(negedge clk);
        check("reset_status", status, 0);
        check("reset_control", Control, 0);
        check("reset_misc", {bus_start, act_crono, grant, alarm_hit, sync, err}, 0);
        push(1, 2'b01, 3'd1, 2'b00, 0);
        push(1, 2'b10, 3'd2, 2'b00, 0);
        push(0, 2'b00, 3'd0, 2'b00, 0);
        resetM = 1'b0;
        wait_bs(c);
        @(negedge clk);
        check("init_control_hold", {Control, status}, {2'b01, 3'd1});
        wait_st(0, e);
        wait_bs(c);
        check("first_read_period", c - e, 100);
        wait_st(0, e);
        // alarm match on slot 0, slot 1 enabled but not matching
        alarm_en = 2'b11;
        hora = 24'h110001;
        push(1, 2'b10, 3'd2, 2'b00, 0);
        push(0, 2'b00, 3'd0, 2'b01, 0);
        wait_bs(c);
        wait_st(0, e);
        check("alarm_hit_slot0", alarm_hit, 2'b01);
        alarm_en = 2'b00;
        repeat (2) @(negedge clk);
        check("alarm_clear", alarm_hit, 2'b00);
        alarm_en = 2'b10;
        hora = 24'h235959;
        push(1, 2'b10, 3'd2, 2'b00, 0);
        push(0, 2'b00, 3'd0, 2'b10, 0);
        wait_bs(c);
        wait_st(0, e);
        check("alarm_hit_slot1", alarm_hit, 2'b10);
        alarm_en = 2'b00;
        repeat (2) @(negedge clk);
        check("alarm_clear2", alarm_hit, 2'b00);
        // priority grant and ignoring other requests while programming
        req = 3'b110;
        repeat (2) @(negedge clk);
        check("prog_grant1", {status, grant, act_crono}, {3'd3, 2'd1, 1'b0});
        req = 3'b111;
        repeat (3) @(negedge clk);
        check("prog_hold", {status, grant}, {3'd3, 2'd1});
        push(1, 2'b11, 3'd4, 2'b00, 0);
        req = 3'b101;
        wait_bs(c);
        req = 3'b000;
        wait_st(0, e);
        // chronometer request suppresses periodic reads
        req = 3'b100;
        repeat (2) @(negedge clk);
        check("crono_enter", {status, grant, act_crono}, {3'd3, 2'd2, 1'b1});
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (act_crono !== 1'b1 || bus_start !== 1'b0 || status !== 3'd3) bad++;
        end
        check("crono_500_cycles", bad, 0);
        push(1, 2'b11, 3'd4, 2'b00, 0);
        req = 3'b000;
        wait_bs(c);
        check("crono_off_in_write", act_crono, 0);
        wait_st(0, e);
        // read timeout, then a bus_done exactly at the timeout cycle
        bus_delay = -1;
        push(1, 2'b10, 3'd2, 2'b00, 0);
        wait_bs(c);
        wait_st(0, t);
        check("timeout_cycle", t - c, 65);
        check("timeout_err", err, 1);
        check("timeout_no_sync", sync, 0);
        bus_delay = 64;
        push(1, 2'b10, 3'd2, 2'b00, 1);
        push(0, 2'b00, 3'd0, 2'b00, 0);
        wait_bs(c);
        wait_st(0, e);
        check("done_at_timeout_clears_err", err, 0);
        bus_delay = 3;
        // r_rtc, read tick and req[0] in the same idle cycle
        push(1, 2'b01, 3'd1, 2'b00, 0);
        push(1, 2'b10, 3'd2, 2'b00, 0);
        push(0, 2'b00, 3'd0, 2'b00, 0);
        repeat (99) @(posedge clk);
        #1;
        r_rtc = 1'b1;
        req = 3'b001;
        wait_bs(c);
        r_rtc = 1'b0;
        wait_bs(c);
        wait_st(0, e);
        repeat (2) @(negedge clk);
        check("pending_prog_grant0", {status, grant, act_crono}, {3'd3, 2'd0, 1'b0});
        push(1, 2'b11, 3'd4, 2'b00, 0);
        req = 3'b000;
        wait_bs(c);
        wait_st(0, e);
        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
